// File: rtl/router_pkg.sv
// Shared router definitions: FIFO entry layout, scheduler states and
// the stall-counter width helper.
package router_pkg;

    localparam int ENTRY_W = 9;
    localparam int EOP_BIT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        ABORT = 2'd2
    } sched_state_t;

    // Counter must be able to hold the value stall_max itself.
    function automatic int stall_w(input int stall_max);
        return $clog2(stall_max + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: grants the first requester strictly
// after ptr, wrapping, so ptr itself has the lowest priority.
module rr_arbiter #(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]         req,
    input  logic [$clog2(NUM_PORTS)-1:0] ptr,
    output logic [NUM_PORTS-1:0]         gnt,
    output logic [$clog2(NUM_PORTS)-1:0] gnt_idx,
    output logic                         valid
);

    localparam int PW = $clog2(NUM_PORTS);

    always_comb begin
        logic [PW-1:0] cand;
        gnt     = '0;
        gnt_idx = '0;
        valid   = 1'b0;
        cand    = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = PW'((int'(ptr) + i) % NUM_PORTS);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/port_out_sched.sv
// Egress scheduler: drains per-port packet FIFOs onto one byte bus with
// packet-atomic round-robin grants, parity checking and stall abort.
module port_out_sched
    import router_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int STALL_MAX = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0]              fifo_empty,
    input  logic [NUM_PORTS-1:0][ENTRY_W-1:0] fifo_dout,
    output logic [NUM_PORTS-1:0]              read_enb,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [7:0]                        out_data,
    output logic                              out_sop,
    output logic                              out_eop,
    output logic                              out_perr,
    output logic                              out_abort,
    output logic [NUM_PORTS-1:0]              grant,
    output logic                              busy
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int SW = stall_w(STALL_MAX);

    sched_state_t         state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [PW-1:0]        gidx_q, gidx_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                 first_q, first_d;
    logic [7:0]           acc_q, acc_d;
    logic [SW-1:0]        stall_q, stall_d;
    logic                 out_valid_q, out_valid_d;
    logic [7:0]           out_data_q, out_data_d;
    logic                 out_sop_q, out_sop_d;
    logic                 out_eop_q, out_eop_d;
    logic                 out_perr_q, out_perr_d;
    logic                 out_abort_q, out_abort_d;

    logic [NUM_PORTS-1:0] arb_gnt;
    logic [PW-1:0]        arb_idx;
    logic                 arb_valid;

    logic                 can_load;
    logic                 cur_empty;
    logic [ENTRY_W-1:0]   cur_entry;
    logic                 pop;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .req     (~fifo_empty),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .valid   (arb_valid)
    );

    assign can_load  = !out_valid_q || out_ready;
    assign cur_empty = fifo_empty[gidx_q];
    assign cur_entry = fifo_dout[gidx_q];
    assign pop       = (state_q == XFER) && can_load && !cur_empty;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        first_d     = first_q;
        acc_d       = acc_q;
        stall_d     = stall_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_perr_d  = out_perr_q;
        out_abort_d = out_abort_q;
        read_enb    = pop ? grant_q : '0;

        // Once the current beat is taken, the register empties unless reloaded below.
        if (can_load) begin
            out_valid_d = 1'b0;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b0;
            out_perr_d  = 1'b0;
            out_abort_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_gnt;
                    gidx_d  = arb_idx;
                    first_d = 1'b1;
                    acc_d   = '0;
                    stall_d = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (pop) begin
                    out_valid_d = 1'b1;
                    out_data_d  = cur_entry[7:0];
                    out_sop_d   = first_q;
                    first_d     = 1'b0;
                    acc_d       = acc_q ^ cur_entry[7:0];
                    stall_d     = '0;
                    if (cur_entry[EOP_BIT]) begin
                        out_eop_d  = 1'b1;
                        out_perr_d = ((acc_q ^ cur_entry[7:0]) != 8'h00);
                        acc_d      = '0;
                        grant_d    = '0;
                        rr_ptr_d   = gidx_q;
                        state_d    = IDLE;
                    end
                end else if (can_load && cur_empty) begin
                    // Only a starved FIFO counts; a blocked sink is not a stall.
                    stall_d = stall_q + 1'b1;
                    if (stall_d == SW'(STALL_MAX)) begin
                        state_d = ABORT;
                    end
                end
            end
            ABORT: begin
                if (can_load) begin
                    out_valid_d = 1'b1;
                    out_data_d  = 8'h00;
                    out_eop_d   = 1'b1;
                    out_perr_d  = 1'b1;
                    out_abort_d = 1'b1;
                    acc_d       = '0;
                    stall_d     = '0;
                    grant_d     = '0;
                    rr_ptr_d    = gidx_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= PW'(NUM_PORTS - 1);
            first_q     <= 1'b0;
            acc_q       <= '0;
            stall_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_perr_q  <= 1'b0;
            out_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            rr_ptr_q    <= rr_ptr_d;
            first_q     <= first_d;
            acc_q       <= acc_d;
            stall_q     <= stall_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_perr_q  <= out_perr_d;
            out_abort_q <= out_abort_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_perr  = out_perr_q;
    assign out_abort = out_abort_q;
    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_port_out_sched.sv
// Bench for port_out_sched: behavioural FIFOs, a packet-level round-robin
// reference model feeding an expected-beat queue, and a negedge monitor.
module tb_port_out_sched;

    localparam int N  = 4;
    localparam int BW = N + 4 + 8;  // {src port one-hot, sop, eop, perr, abort, data}

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      fifo_empty;
    logic [N-1:0][8:0] fifo_dout;
    logic [N-1:0]      read_enb;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              out_sop, out_eop, out_perr, out_abort;
    logic [N-1:0]      grant;
    logic              busy;

    logic [8:0]    fq[N][$];    // FIFO contents seen by the DUT
    logic [8:0]    pend[N][$];  // entries written this cycle, land after the next edge
    logic [8:0]    mq[N][$];    // reference model copy of loaded packets
    logic [7:0]    pkt_buf[$];
    logic [BW-1:0] exp_q[$];
    logic [N-1:0]  src_q[$];
    int            m_ptr;
    int            n_checks = 0;
    int            n_pass   = 0;
    bit            bp_en    = 1'b0;
    bit            hold_low = 1'b0;

    port_out_sched #(.NUM_PORTS(N), .STALL_MAX(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .read_enb   (read_enb),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_perr   (out_perr),
        .out_abort  (out_abort),
        .grant      (grant),
        .busy       (busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    // behavioural FIFOs: pop on sampled read_enb, cleared by the shared reset
    initial begin
        logic [N-1:0] re;
        fifo_empty = '1;
        fifo_dout  = '0;
        forever begin
            @(negedge clk);
            re = read_enb;
            @(posedge clk);
            #1;
            for (int p = 0; p < N; p++) begin
                if (!reset) fq[p].delete();
                else if (re[p] && fq[p].size() > 0) void'(fq[p].pop_front());
                while (pend[p].size() > 0) fq[p].push_back(pend[p].pop_front());
                fifo_empty[p] = (fq[p].size() == 0);
                fifo_dout[p]  = (fq[p].size() > 0) ? fq[p][0] : 9'h000;
            end
        end
    end

    // sink readiness
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (hold_low)   out_ready = 1'b0;
            else if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
            else            out_ready = 1'b1;
        end
    end

    // monitor: compares accepted beats against the expected queue
    initial begin
        logic          hold;
        logic [11:0]   prev, cur;
        logic [N-1:0]  last_src, src;
        hold = 1'b0; prev = '0; last_src = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hold = 1'b0;
                continue;
            end
            cur = {out_sop, out_eop, out_perr, out_abort, out_data};
            if (hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_stable", 32'(cur), 32'(prev));
            end
            if (out_valid && !out_ready) chk("bp_no_pop", 32'(read_enb), 32'd0);
            if (out_valid && out_ready) begin
                if (out_abort)              src = last_src;
                else if (src_q.size() > 0)  src = src_q.pop_front();
                else                        src = '0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got %h expected none at %0t", {src, cur}, $time);
                end else begin
                    chk("beat", 32'({src, cur}), 32'(exp_q.pop_front()));
                end
            end
            if (read_enb != '0) begin
                chk("read_enb_granted", 32'(read_enb & ~grant), 32'd0);
                src_q.push_back(read_enb);
                last_src = read_enb;
            end
            hold = out_valid && !out_ready;
            prev = cur;
        end
    end

    // driver tasks
    task automatic load_pkt(input int p);
        for (int i = 0; i < pkt_buf.size(); i++) begin
            pend[p].push_back({(i == pkt_buf.size() - 1), pkt_buf[i]});
            mq[p].push_back({(i == pkt_buf.size() - 1), pkt_buf[i]});
        end
    endtask

    task automatic rand_pkt(input int p, input int len);
        pkt_buf.delete();
        for (int i = 0; i < len; i++) pkt_buf.push_back(8'($urandom_range(0, 255)));
        load_pkt(p);
    endtask

    // Reference: whole packets in round-robin order among loaded ports,
    // parity error whenever the XOR of every byte is nonzero.
    task automatic model_run();
        int           p;
        logic [7:0]   acc;
        logic [8:0]   e;
        logic         first;
        logic [N-1:0] g;
        forever begin
            p = -1;
            for (int i = 1; i <= N; i++) begin
                if (p < 0 && mq[(m_ptr + i) % N].size() > 0) p = (m_ptr + i) % N;
            end
            if (p < 0) break;
            acc = 8'h00; first = 1'b1; g = '0; g[p] = 1'b1;
            do begin
                e = mq[p].pop_front();
                acc ^= e[7:0];
                exp_q.push_back({g, first, e[8], e[8] & (acc != 8'h00), 1'b0, e[7:0]});
                first = 1'b0;
            end while (!e[8]);
            m_ptr = p;
        end
    endtask

    function automatic bit all_idle();
        bit ok = !busy && !out_valid && (exp_q.size() == 0);
        for (int p = 0; p < N; p++) if (fq[p].size() != 0 || pend[p].size() != 0) ok = 0;
        return ok;
    endfunction

    task automatic wait_drain(input int max_cyc);
        int k = 0;
        while (!all_idle() && k < max_cyc) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (k >= max_cyc) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d beats still expected after %0d cycles", exp_q.size(), k);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic clear_model();
        for (int p = 0; p < N; p++) begin
            mq[p].delete();
            pend[p].delete();
        end
        exp_q.delete();
        src_q.delete();
        m_ptr = N - 1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #4;
        reset = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    // stimulus
    initial begin
        int k;
        reset = 1'b0;
        m_ptr = N - 1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_read_enb", 32'(read_enb), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_flags", 32'({out_sop, out_eop, out_perr, out_abort}), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;

        // single packet on port 2
        pkt_buf = '{8'hA5, 8'h01, 8'h02, 8'hA6};
        load_pkt(2);
        model_run();
        wait_drain(200);

        // ports 0 and 3 together, two rounds, from a fresh pointer
        do_reset();
        for (int r = 0; r < 2; r++) begin
            rand_pkt(0, 3);
            rand_pkt(3, 3);
            model_run();
            wait_drain(200);
        end

        // bad parity followed by a good packet on the same port
        pkt_buf = '{8'h10, 8'h20, 8'h31};
        load_pkt(1);
        pkt_buf = '{8'h5A, 8'hA5, 8'hFF};
        load_pkt(1);
        model_run();
        wait_drain(200);

        // 5 cycles of backpressure mid-packet
        rand_pkt(0, 8);
        model_run();
        k = 0;
        while (exp_q.size() > 5 && k < 100) begin
            @(posedge clk);
            k++;
        end
        hold_low = 1'b1;
        repeat (5) @(posedge clk);
        hold_low = 1'b0;
        wait_drain(200);

        // stall: header only on port 1, then three ports compete
        pend[1].push_back({1'b0, 8'h44});
        exp_q.push_back({4'b0010, 4'b1000, 8'h44});
        exp_q.push_back({4'b0010, 4'b0111, 8'h00});
        m_ptr = 1;
        wait_drain(300);
        chk("stall_busy_dropped", 32'(busy), 32'd0);
        rand_pkt(0, 2);
        rand_pkt(1, 2);
        rand_pkt(2, 2);
        model_run();
        wait_drain(200);

        // asynchronous reset mid-transfer
        do_reset();
        rand_pkt(3, 20);
        model_run();
        k = 0;
        while (!out_valid && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #4;
        reset = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_grant", 32'(grant), 32'd0);
        chk("async_rst_read_enb", 32'(read_enb), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        clear_model();
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        rand_pkt(3, 2);
        rand_pkt(0, 2);
        model_run();
        wait_drain(200);

        // randomized rounds with random backpressure
        bp_en = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int p = 0; p < N; p++) begin
                if ($urandom_range(0, 1) == 1 || p == r % N) begin
                    int npk = $urandom_range(1, 3);
                    for (int j = 0; j < npk; j++) rand_pkt(p, $urandom_range(1, 6));
                end
            end
            model_run();
            wait_drain(3000);
        end
        bp_en = 1'b0;
        repeat (4) @(posedge clk);

        // final report
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/port_out_sched.md
Name: port_out_sched

Overview:
Output-side scheduler for the router. Drains the NUM_PORTS per-port packet FIFOs, which the input port FSM fills, onto one shared byte-wide egress bus. Arbitration is round-robin with packet-atomic grants: once a port is granted, its whole packet (header, payload, parity byte) is forwarded before another port is considered. The block also checks each packet's parity and aborts packets that stall on an empty FIFO.

Parameters:
NUM_PORTS, 4, number of source FIFOs (4 or 8).
STALL_MAX, 16, consecutive empty cycles mid-packet before abort (2..255).

Ports:
clk  input  1  clock.
reset  input  1  asynchronous, active-low reset.
fifo_empty  input  NUM_PORTS  per-port FIFO empty flag.
fifo_dout  input  NUM_PORTS x 9  per-port head entry, first-word fall-through; bit 8 = eop, bits 7:0 = byte.
read_enb  output  NUM_PORTS  one-hot pop strobe; FIFO pops at posedge clk.
out_valid  output  1  egress byte valid.
out_ready  input  1  egress sink accepts byte when out_valid & out_ready.
out_data  output  8  egress byte.
out_sop  output  1  first byte of packet (header/address byte).
out_eop  output  1  last byte of packet (parity byte).
out_perr  output  1  parity error; meaningful only on the eop beat.
out_abort  output  1  packet truncated by stall timeout; accompanies a synthetic eop beat.
grant  output  NUM_PORTS  one-hot currently owned port; 0 in IDLE.
busy  output  1  state != IDLE.

Behaviour:
- Reset, async low: state=IDLE; grant=0; rr pointer=NUM_PORTS-1, so port 0 has priority first; read_enb=0; out_valid=0; out_data=0; out_sop/eop/perr/abort=0; parity acc=0; stall cnt=0. FIFO contents are not touched. The system resets the FIFOs with the same reset.
- Output register, single stage: can_load = !out_valid | out_ready. While out_valid=1 and out_ready=0, all out_* signals hold stable.
- States: IDLE, XFER, ABORT.
- IDLE: if any !fifo_empty, select the first non-empty port strictly after the rr pointer (wrapping). grant is registered next cycle; state goes to XFER and first=1. If none is non-empty, stay in IDLE.
- XFER:
  - read_enb[g] = can_load & !fifo_empty[g]. read_enb is combinational and never asserted for a non-granted port.
  - On pop: out_data <= dout[7:0]; out_valid <= 1; out_sop <= first; first <= 0.
  - On pop: acc <= acc ^ byte. If eop, out_eop <= 1 and out_perr <= ((acc ^ byte) != 0).
  - On eop pop: state goes to IDLE, rr pointer <= g, grant <= 0, acc <= 0.
  - If can_load and no pop happens, out_valid <= 0.
- Stall: in XFER, if fifo_empty[g] is 1, the stall counter increments; any pop clears it. When the counter reaches STALL_MAX, go to ABORT.
- ABORT: when can_load, emit one beat: out_valid=1, out_data=0, out_eop=1, out_abort=1, out_perr=1. Then go to IDLE with rr pointer <= g. Remaining bytes of that packet stay in the FIFO; flushing them is the system's job.
- Throughput: 1 byte/cycle while ready and non-empty. Min gap between packets is 1 cycle, spent in IDLE for arbitration. Latency from FIFO non-empty in IDLE to out_valid is 2 cycles.
- Single-byte packet (eop on the first entry): out_sop and out_eop are both 1 on the same beat.
- A port that becomes non-empty while another port is granted waits. Fairness: every requester is served within NUM_PORTS-1 packets.
- If out_ready is held low indefinitely, nothing pops and the stall counter does not count. Backpressure is not a stall.

Decomposition:
- Shared package router_pkg holds:
  - ENTRY_W=9 and EOP_BIT=8
  - the state enum {IDLE, XFER, ABORT}
  - a STALL_W width function
- Sub-module rr_arbiter(NUM_PORTS) is natural: request vector plus pointer in, one-hot grant and valid out, combinational rotate-priority. port_out_sched owns the pointer register.

Test Plan:
- Single packet on port 2: entries A5,01,02,(eop)A6, out_ready=1 → grant=0100; out_data A5(sop),01,02,A6(eop); out_perr=0.
- Ports 0 and 3 both loaded with 3-byte packets, ready=1 → port 0 packet complete, 1 IDLE cycle, then port 3 packet; no interleaving; the next round starts at port 0 again only after port 3 is served.
- Bad parity: 10,20,(eop)31 → eop beat out_perr=1; a following good packet shows out_perr=0.
- Backpressure: out_ready low for 5 cycles mid-packet → out_data and flags held, read_enb=0, no byte lost or duplicated, no abort.
- Stall: port 1 gives header 44 then runs empty for 16 cycles → out_abort=1, out_eop=1, out_data=00; busy drops; port 1 is re-granted only after other requesters.
- Reset asserted mid-XFER → out_valid, grant, read_enb go to 0 immediately (asynchronously); after release, port 0 has priority first.
